ram_readback_checker: RTL
=========================

# ram_readback_checker

Read-side counterpart to the address/data write generator in the RAM experiment. After the generator has filled the single-port RAM, this block sweeps every address and captures the RAM output `q`. It compares each word against the known fill pattern, then reports an error count, a pass flag and optionally the first failing location. It shares `clk` and `rst_n` with the RAM and the generator, and drives the RAM address and read-enable while `busy` is high.

## Interface
- `ADDR_W`, 8, RAM address width.
- `DATA_W`, 8, RAM data width.
- `DEPTH`, 256, number of words swept, from address 0 to DEPTH-1. Must satisfy DEPTH ≤ 2^ADDR_W.
- `RD_LAT`, 2, cycles from address presented to `q` valid. Legal range is 1..4.
- `OFFSET`, 0, pattern constant. Expected data = (addr + OFFSET) mod 2^DATA_W.
- `CNT_W`, 9, error counter width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to begin a sweep.
- `q`  in  DATA_W  RAM read data.
- `addr`  out  ADDR_W  RAM address.
- `rden`  out  1  RAM read enable.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep complete. Held high until the next accepted `start`.
- `pass`  out  1  valid when `done`=1. High iff `err_cnt`==0.
- `err_cnt`  out  CNT_W  mismatches counted, saturating.
- `first_err_addr`  out  ADDR_W  present only with `RAM_CHK_FIRST_ERR_EN`.
- `first_err_data`  out  DATA_W  present only with `RAM_CHK_FIRST_ERR_EN`.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: `start`=1 clears `err_cnt` and the first-error registers, loads the issue counter with 0, and moves to READ.
- READ: each cycle drives `addr` = issue counter and `rden`=1, pushes a valid bit and the address into an RD_LAT-deep alignment pipe, then increments the counter. When address DEPTH-1 has been issued, the FSM moves to DRAIN.
- DRAIN: `rden`=0 and `addr` holds its last value. After RD_LAT cycles the pipe is empty and the FSM moves to DONE.
- DONE: `done`=1 and `busy`=0. A `start` here behaves exactly as in IDLE and restarts the sweep.
- Compare: when the pipe output is valid, `q` is compared with (pipe_addr + OFFSET) truncated to DATA_W.
- On mismatch, `err_cnt` increments and saturates at 2^CNT_W-1.
- `start` while `busy`=1 is ignored.
- `addr` never exceeds DEPTH-1, so there is no wrap-around within a sweep.
- If DEPTH == 2^ADDR_W, the issue counter needs ADDR_W+1 bits internally so the terminal condition is detectable.
- `rst_n` low at any time, including mid-sweep:
  - the FSM returns to IDLE and the pipe is flushed;
  - all outputs take their reset values immediately;
  - no partial result is reported.
- Reset values: `addr`=0, `rden`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_err_addr`=0, `first_err_data`=0.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high.
- Issue window: `busy` rises and `rden`/`addr`=0 appear in cycle 1. Address k is driven in cycle 1+k.
- Comparison: the word for address k is compared in cycle 1+k+RD_LAT. `err_cnt` reflects it from cycle 2+k+RD_LAT.
- Completion: `busy` falls and `done`/`pass` are valid from cycle DEPTH+RD_LAT+1.
- All outputs are registered. There is no combinational path from `q` or `start` to any output.

## Configuration
- `RAM_CHK_FIRST_ERR_EN` defined:
  - `first_err_addr` and `first_err_data` exist;
  - on the first mismatch of a sweep they latch the address and the received `q`;
  - later mismatches leave them unchanged;
  - they are cleared on an accepted `start`.
- Not defined: both ports and their registers are absent. All other behaviour is identical.

## Test plan
- Correct fill (`q` model returns addr+OFFSET, OFFSET=0, DEPTH=256, RD_LAT=2): `start` at cycle 0 gives `done`=1, `pass`=1, `err_cnt`=0 at cycle 259, with `busy` high during cycles 1..258.
- Single corrupt word (address 0x37 returns 0xFF): `err_cnt`=1 and `pass`=0 at done. With the macro, `first_err_addr`=0x37 and `first_err_data`=0xFF.
- All words wrong with CNT_W=4: `err_cnt` saturates at 15. With the macro, `first_err_addr`=0.
- `start` pulsed in cycle 100 of a sweep: ignored, and `done` still occurs at cycle 259. A second `start` in DONE clears `err_cnt` and repeats the sweep.
- `rst_n` low for 3 cycles at cycle 120: all outputs are 0 within the reset cycle, and the block stays in IDLE until the next `start`.
- RD_LAT=1, DEPTH=16, OFFSET=5: expected word for address 15 is 20 (0x14), and `done` is asserted at cycle 18.

Source files
------------

// File: rtl/ram_readback_checker.sv
//=============================================================================
// Module      : ram_readback_checker
// Description : Sweeps RAM addresses 0..DEPTH-1 after a fill and checks every
//               word against (addr + OFFSET) mod 2^DATA_W. It reports a
//               saturating error count and a pass flag.
//               Optional macro RAM_CHK_FIRST_ERR_EN adds first-failure capture.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none
`timescale 1ns/1ps

module ram_readback_checker #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2,
    parameter int OFFSET = 0,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] q,
    output logic [ADDR_W-1:0] addr,
    output logic              rden,
    output logic              busy,
    output logic              done,
    output logic              pass,
`ifdef RAM_CHK_FIRST_ERR_EN
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
`else
    output logic [CNT_W-1:0]  err_cnt
`endif
);

    localparam logic [1:0]        c_IDLE       = 2'd0;
    localparam logic [1:0]        c_READ       = 2'd1;
    localparam logic [1:0]        c_DRAIN      = 2'd2;
    localparam logic [1:0]        c_DONE       = 2'd3;
    localparam logic [ADDR_W:0]   c_LAST       = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   c_ISSUE_ONE  = (ADDR_W+1)'(1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  c_CNT_ONE    = CNT_W'(1);
    localparam logic [1:0]        c_DRAIN_LAST = 2'(RD_LAT - 1);

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_issue;
    logic              r_rden;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [1:0]        r_drain;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [RD_LAT-1:0][ADDR_W-1:0] r_pipe_addr;

    logic [1:0]        w_state_nxt;
    logic [ADDR_W:0]   w_issue_nxt;
    logic              w_rden_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_pass_nxt;
    logic [1:0]        w_drain_nxt;
    logic              w_clear;
    logic [DATA_W-1:0] w_exp;
    logic              w_mis;
    logic [CNT_W-1:0]  w_err_nxt;

    // Pipe output lines up with q for the address issued RD_LAT cycles earlier
    always_comb begin
        w_exp = DATA_W'(r_pipe_addr[RD_LAT-1]) + DATA_W'(OFFSET);
        w_mis = r_pipe_vld[RD_LAT-1] && (q != w_exp);
        w_err_nxt = r_err_cnt;
        if (w_clear) begin
            w_err_nxt = '0;
        end else if (w_mis && (r_err_cnt != c_CNT_MAX)) begin
            w_err_nxt = r_err_cnt + c_CNT_ONE;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue_nxt = r_issue;
        w_rden_nxt  = r_rden;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_drain_nxt = r_drain;
        w_clear     = 1'b0;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = c_READ;
                    w_issue_nxt = '0;
                    w_rden_nxt  = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                end
            end
            c_READ: begin
                if (r_issue == c_LAST) begin
                    w_state_nxt = c_DRAIN;
                    w_rden_nxt  = 1'b0;
                    w_drain_nxt = '0;
                end else begin
                    w_issue_nxt = r_issue + c_ISSUE_ONE;
                end
            end
            c_DRAIN: begin
                // Last compare happens this cycle, so pass uses the updated count
                if (r_drain == c_DRAIN_LAST) begin
                    w_state_nxt = c_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_err_nxt == '0);
                end else begin
                    w_drain_nxt = r_drain + 2'd1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_issue   <= '0;
            r_rden    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_drain   <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_issue   <= w_issue_nxt;
            r_rden    <= w_rden_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_pass    <= w_pass_nxt;
            r_drain   <= w_drain_nxt;
            r_err_cnt <= w_err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld  <= '0;
            r_pipe_addr <= '0;
        end else begin
            r_pipe_vld[0]  <= r_rden;
            r_pipe_addr[0] <= r_issue[ADDR_W-1:0];
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end
        end
    end

`ifdef RAM_CHK_FIRST_ERR_EN
    logic [ADDR_W-1:0] r_first_addr;
    logic [DATA_W-1:0] r_first_data;

    // A zero count means no mismatch yet in this sweep; saturation never returns to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first_addr <= '0;
            r_first_data <= '0;
        end else if (w_clear) begin
            r_first_addr <= '0;
            r_first_data <= '0;
        end else if (w_mis && (r_err_cnt == '0)) begin
            r_first_addr <= r_pipe_addr[RD_LAT-1];
            r_first_data <= q;
        end
    end

    assign first_err_addr = r_first_addr;
    assign first_err_data = r_first_data;
`endif

    assign addr    = r_issue[ADDR_W-1:0];
    assign rden    = r_rden;
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign err_cnt = r_err_cnt;

endmodule

`default_nettype wire
